axi_mport_bridge: RTL and testbench

- Parametrised successor to the single inst/data SRAM-like-to-AXI bridge.
- Accepts NUM_PORTS SRAM-like request ports (req/addr_ok/data_ok) from the core and round-robin arbitrates them onto one AXI3 master.
- Each port may have one outstanding transaction. The port index is used as the AXI ID, so reads from different ports overlap and complete out of order.
- Sits between the mips core and the system cache / interconnect.

---
 rtl/axi_mport_bridge.sv | 273 +++++++++++++++++++++++++++
 tb/tb_axi_mport_bridge.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mport_bridge.sv
// axi_mport_bridge: round-robin arbiter of NUM_PORTS SRAM-like ports onto one AXI3 master,
// using the port index as the AXI ID. Optional macro AXI_MPORT_BRIDGE_RESP_ERR_EN adds resp_err.
module axi_mport_bridge #(
  parameter int NUM_PORTS = 2,
  parameter int ID_W      = 4,
  parameter int ADDR_W    = 32
) (
  input  logic                        aclk,
  input  logic                        aresetn,

  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        wr,
  input  logic [2*NUM_PORTS-1:0]      size,
  input  logic [ADDR_W*NUM_PORTS-1:0] addr,
  input  logic [32*NUM_PORTS-1:0]     wdata,
  input  logic [NUM_PORTS-1:0]        uncached,
  output logic [NUM_PORTS-1:0]        addr_ok,
  output logic [NUM_PORTS-1:0]        data_ok,
`ifdef AXI_MPORT_BRIDGE_RESP_ERR_EN
  output logic [NUM_PORTS-1:0]        resp_err,
`endif
  output logic [31:0]                 rdata,

  output logic [ID_W-1:0]             arid,
  output logic [ADDR_W-1:0]           araddr,
  output logic [3:0]                  arlen,
  output logic [2:0]                  arsize,
  output logic [1:0]                  arburst,
  output logic [1:0]                  arlock,
  output logic [3:0]                  arcache,
  output logic [2:0]                  arprot,
  output logic                        arvalid,
  input  logic                        arready,

  input  logic [ID_W-1:0]             rid,
  input  logic [31:0]                 rdata_axi,
  input  logic [1:0]                  rresp,
  input  logic                        rlast,
  input  logic                        rvalid,
  output logic                        rready,

  output logic [ID_W-1:0]             awid,
  output logic [ADDR_W-1:0]           awaddr,
  output logic [3:0]                  awlen,
  output logic [2:0]                  awsize,
  output logic [1:0]                  awburst,
  output logic [1:0]                  awlock,
  output logic [3:0]                  awcache,
  output logic [2:0]                  awprot,
  output logic                        awvalid,
  input  logic                        awready,

  output logic [ID_W-1:0]             wid,
  output logic [31:0]                 wdata_axi,
  output logic [3:0]                  wstrb,
  output logic                        wlast,
  output logic                        wvalid,
  input  logic                        wready,

  input  logic [ID_W-1:0]             bid,
  input  logic [1:0]                  bresp,
  input  logic                        bvalid,
  output logic                        bready
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CNT_W = $clog2(NUM_PORTS + 1);

  typedef enum logic {IDLE, BUSY} port_state_e;

  port_state_e          state_q [NUM_PORTS];
  port_state_e          state_d [NUM_PORTS];
  logic [NUM_PORTS-1:0] isWr_q, isWr_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]     wrCnt_q, wrCnt_d;

  logic                 arvalid_q;
  logic [ID_W-1:0]      arid_q;
  logic [ADDR_W-1:0]    araddr_q;
  logic [2:0]           arsize_q;
  logic [3:0]           arcache_q;

  logic                 awvalid_q;
  logic [ID_W-1:0]      awid_q;
  logic [ADDR_W-1:0]    awaddr_q;
  logic [2:0]           awsize_q;
  logic [3:0]           awcache_q;

  logic                 wvalid_q;
  logic [ID_W-1:0]      wid_q;
  logic [31:0]          wdata_q;
  logic [3:0]           wstrb_q;

  logic [31:0]          rdata_q;
  logic                 rready_q;

  logic                 arFree, awFree;
  logic [NUM_PORTS-1:0] elig, rDone, bDone;
  logic                 grantValid;
  logic [PTR_W-1:0]     grantIdx;
  int                   searchIdx;

  logic                 gWr, gUnc;
  logic [1:0]           gSize;
  logic [ADDR_W-1:0]    gAddr;
  logic [31:0]          gWdata;
  logic [3:0]           gStrb;

  // A holding register can take a new request if it is empty or draining this cycle.
  assign arFree = !arvalid_q || arready;
  assign awFree = (!awvalid_q || awready) && (!wvalid_q || wready);

  always_comb begin
    rDone = '0;
    bDone = '0;
    elig  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      rDone[i] = aresetn && rvalid && rready_q && (rid == ID_W'(i)) &&
                 (state_q[i] == BUSY) && !isWr_q[i];
      bDone[i] = aresetn && bvalid && (bid == ID_W'(i)) &&
                 (state_q[i] == BUSY) && isWr_q[i];
      elig[i]  = aresetn && req[i] && (state_q[i] == IDLE) &&
                 (wr[i] ? awFree : (arFree && (wrCnt_q == '0)));
    end
  end

  // Round-robin search starting at the pointer; the first eligible port wins.
  always_comb begin
    grantValid = 1'b0;
    grantIdx   = '0;
    searchIdx  = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      searchIdx = (int'(ptr_q) + k) % NUM_PORTS;
      if (!grantValid && elig[searchIdx]) begin
        grantValid = 1'b1;
        grantIdx   = PTR_W'(searchIdx);
      end
    end
  end

  always_comb begin
    gWr    = wr[grantIdx];
    gUnc   = uncached[grantIdx];
    gSize  = size[grantIdx*2 +: 2];
    gAddr  = addr[grantIdx*ADDR_W +: ADDR_W];
    gWdata = wdata[grantIdx*32 +: 32];
    case (gSize)
      2'd0:    gStrb = 4'b0001 << gAddr[1:0];
      2'd1:    gStrb = 4'b0011 << gAddr[1:0];
      default: gStrb = 4'b1111;
    endcase
  end

  always_comb begin
    state_d = state_q;
    isWr_d  = isWr_q;
    ptr_d   = ptr_q;
    addr_ok = '0;
    data_ok = rDone | bDone;
    if (grantValid) begin
      addr_ok[grantIdx] = 1'b1;
      state_d[grantIdx] = BUSY;
      isWr_d[grantIdx]  = gWr;
      ptr_d = (grantIdx == PTR_W'(NUM_PORTS - 1)) ? '0 : grantIdx + 1'b1;
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (rDone[i] || bDone[i]) state_d[i] = IDLE;
    end
    wrCnt_d = wrCnt_q + CNT_W'(grantValid && gWr) - CNT_W'(|bDone);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_PORTS; i++) state_q[i] <= IDLE;
      isWr_q    <= '0;
      ptr_q     <= '0;
      wrCnt_q   <= '0;
      arvalid_q <= 1'b0;
      arid_q    <= '0;
      araddr_q  <= '0;
      arsize_q  <= '0;
      arcache_q <= '0;
      awvalid_q <= 1'b0;
      awid_q    <= '0;
      awaddr_q  <= '0;
      awsize_q  <= '0;
      awcache_q <= '0;
      wvalid_q  <= 1'b0;
      wid_q     <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      rready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      isWr_q   <= isWr_d;
      ptr_q    <= ptr_d;
      wrCnt_q  <= wrCnt_d;
      rready_q <= 1'b1;
      if (|rDone) rdata_q <= rdata_axi;

      if (grantValid && !gWr) begin
        arvalid_q <= 1'b1;
        arid_q    <= ID_W'(grantIdx);
        araddr_q  <= gAddr;
        arsize_q  <= {1'b0, gSize};
        arcache_q <= gUnc ? 4'b0000 : 4'b1111;
      end else if (arready) begin
        arvalid_q <= 1'b0;
      end

      // AW and W load together on a write grant but drain independently.
      if (grantValid && gWr) begin
        awvalid_q <= 1'b1;
        awid_q    <= ID_W'(grantIdx);
        awaddr_q  <= gAddr;
        awsize_q  <= {1'b0, gSize};
        awcache_q <= gUnc ? 4'b0000 : 4'b1111;
      end else if (awready) begin
        awvalid_q <= 1'b0;
      end

      if (grantValid && gWr) begin
        wvalid_q <= 1'b1;
        wid_q    <= ID_W'(grantIdx);
        wdata_q  <= gWdata;
        wstrb_q  <= gStrb;
      end else if (wready) begin
        wvalid_q <= 1'b0;
      end
    end
  end

  assign arid      = arid_q;
  assign araddr    = araddr_q;
  assign arlen     = 4'd0;
  assign arsize    = arsize_q;
  assign arburst   = 2'b01;
  assign arlock    = 2'b00;
  assign arcache   = arcache_q;
  assign arprot    = 3'b000;
  assign arvalid   = arvalid_q && aresetn;

  assign awid      = awid_q;
  assign awaddr    = awaddr_q;
  assign awlen     = 4'd0;
  assign awsize    = awsize_q;
  assign awburst   = 2'b01;
  assign awlock    = 2'b00;
  assign awcache   = awcache_q;
  assign awprot    = 3'b000;
  assign awvalid   = awvalid_q && aresetn;

  assign wid       = wid_q;
  assign wdata_axi = wdata_q;
  assign wstrb     = wstrb_q;
  assign wlast     = 1'b1;
  assign wvalid    = wvalid_q && aresetn;

  assign rready    = rready_q && aresetn;
  assign bready    = rready_q && aresetn;
  assign rdata     = (|rDone) ? rdata_axi : rdata_q;

`ifdef AXI_MPORT_BRIDGE_RESP_ERR_EN
  assign resp_err = (rDone & {NUM_PORTS{rresp[1]}}) | (bDone & {NUM_PORTS{bresp[1]}});
  logic unusedBits;
  assign unusedBits = ^{rlast, rresp[0], bresp[0]};
`else
  logic unusedBits;
  assign unusedBits = ^{rlast, rresp, bresp};
`endif

endmodule

// File: tb/tb_axi_mport_bridge.sv
// Self-checking bench for axi_mport_bridge (2 ports): table-driven single transactions
// followed by hand-written multi-cycle sequences.
module tb_axi_mport_bridge;

   localparam int NP  = 2;
   localparam int IDW = 4;
   localparam int AW  = 32;

   logic              aclk;
   logic              aresetn;
   logic [NP-1:0]     req, wr, uncached;
   logic [2*NP-1:0]   size;
   logic [AW*NP-1:0]  addr;
   logic [32*NP-1:0]  wdata;
   logic [NP-1:0]     addr_ok, data_ok;
`ifdef AXI_MPORT_BRIDGE_RESP_ERR_EN
   logic [NP-1:0]     resp_err;
`endif
   logic [31:0]       rdata;
   logic [IDW-1:0]    arid, awid, wid, rid, bid;
   logic [AW-1:0]     araddr, awaddr;
   logic [3:0]        arlen, awlen, arcache, awcache, wstrb;
   logic [2:0]        arsize, awsize, arprot, awprot;
   logic [1:0]        arburst, awburst, arlock, awlock, rresp, bresp;
   logic              arvalid, arready, awvalid, awready, wvalid, wready, wlast;
   logic [31:0]       rdata_axi, wdata_axi;
   logic              rlast, rvalid, rready, bvalid, bready;

   int checks = 0;
   int errors = 0;
   int expPtr = 0;

   typedef struct {
      int          port;
      logic        isWr;
      logic [1:0]  sz;
      logic [31:0] ad;
      logic [31:0] wd;
      logic        unc;
      logic [31:0] rd;
      logic [2:0]  expSize;
      logic [3:0]  expStrb;
      logic [3:0]  expCache;
   } vec_t;

   vec_t vecs [7];

   axi_mport_bridge #(.NUM_PORTS(NP), .ID_W(IDW), .ADDR_W(AW)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata), .uncached(uncached),
      .addr_ok(addr_ok), .data_ok(data_ok),
`ifdef AXI_MPORT_BRIDGE_RESP_ERR_EN
      .resp_err(resp_err),
`endif
      .rdata(rdata),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata_axi(rdata_axi), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata_axi(wdata_axi), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   // 10 ns clock
   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   // Safety net so the run always ends
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   // Compare one observed value against its expected value
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   // Drive one port's request fields; all other ports idle
   task automatic drivePort(input int p, input logic isWr, input logic [1:0] sz,
                            input logic [31:0] ad, input logic [31:0] wd, input logic unc);
      req = '0;
      wr  = '0;
      req[p] = 1'b1;
      wr[p]  = isWr;
      size[p*2 +: 2]   = sz;
      addr[p*AW +: AW] = ad;
      wdata[p*32 +: 32] = wd;
      uncached[p] = unc;
   endtask

   // Run one full single-port transaction from a table record with all readies high
   task automatic applyStimulus(input vec_t v);
      logic [NP-1:0] oneHot;
      oneHot = '0;
      oneHot[v.port] = 1'b1;
      drivePort(v.port, v.isWr, v.sz, v.ad, v.wd, v.unc);
      #1;
      checkOutput("vec addr_ok", addr_ok, oneHot);
      expPtr = (v.port + 1) % NP;
      tick();
      req = '0;
      #1;
      if (v.isWr) begin
         checkOutput("vec awvalid", awvalid, 1);
         checkOutput("vec wvalid", wvalid, 1);
         checkOutput("vec awid", awid, v.port);
         checkOutput("vec wid", wid, v.port);
         checkOutput("vec awaddr", awaddr, v.ad);
         checkOutput("vec awsize", awsize, v.expSize);
         checkOutput("vec awcache", awcache, v.expCache);
         checkOutput("vec wstrb", wstrb, v.expStrb);
         checkOutput("vec wdata_axi", wdata_axi, v.wd);
         checkOutput("vec awfixed", {awlen, awburst, awlock, awprot, wlast}, {4'd0, 2'b01, 2'b00, 3'b000, 1'b1});
      end else begin
         checkOutput("vec arvalid", arvalid, 1);
         checkOutput("vec arid", arid, v.port);
         checkOutput("vec araddr", araddr, v.ad);
         checkOutput("vec arsize", arsize, v.expSize);
         checkOutput("vec arcache", arcache, v.expCache);
         checkOutput("vec arfixed", {arlen, arburst, arlock, arprot}, {4'd0, 2'b01, 2'b00, 3'b000});
      end
      tick();
      #1;
      checkOutput("vec valids drained", {arvalid, awvalid, wvalid}, 3'b000);
      checkOutput("vec no early data_ok", data_ok, 0);
      if (v.isWr) begin
         bvalid = 1'b1;
         bid = IDW'(v.port);
      end else begin
         rvalid = 1'b1;
         rid = IDW'(v.port);
         rdata_axi = v.rd;
      end
      #1;
      checkOutput("vec data_ok", data_ok, oneHot);
      if (!v.isWr) checkOutput("vec rdata", rdata, v.rd);
`ifdef AXI_MPORT_BRIDGE_RESP_ERR_EN
      checkOutput("vec resp_err", resp_err, 0);
`endif
      tick();
      rvalid = 1'b0;
      bvalid = 1'b0;
   endtask

   initial begin
      logic [NP-1:0] reqM, busyM, expGrant;
      int            grantCyc [NP];
      int            respPort;

      vecs[0] = '{1, 1'b0, 2'd2, 32'h1FC00010, 32'h0,        1'b1, 32'hDEADBEEF, 3'd2, 4'b1111, 4'h0};
      vecs[1] = '{0, 1'b1, 2'd0, 32'h80000003, 32'hAB000000, 1'b0, 32'h0,        3'd0, 4'b1000, 4'hF};
      vecs[2] = '{0, 1'b0, 2'd1, 32'h00001002, 32'h0,        1'b0, 32'h12345678, 3'd1, 4'b1111, 4'hF};
      vecs[3] = '{1, 1'b1, 2'd1, 32'h00000002, 32'h55660000, 1'b1, 32'h0,        3'd1, 4'b1100, 4'h0};
      vecs[4] = '{1, 1'b1, 2'd2, 32'h00000100, 32'h01020304, 1'b0, 32'h0,        3'd2, 4'b1111, 4'hF};
      vecs[5] = '{0, 1'b1, 2'd0, 32'h00000001, 32'h0000CD00, 1'b1, 32'h0,        3'd0, 4'b0010, 4'h0};
      vecs[6] = '{0, 1'b0, 2'd3, 32'h00000010, 32'h0,        1'b0, 32'hCAFEF00D, 3'd3, 4'b1111, 4'hF};

      aresetn = 1'b0;
      req = '0; wr = '0; size = '0; addr = '0; wdata = '0; uncached = '0;
      arready = 1'b1; awready = 1'b1; wready = 1'b1;
      rid = '0; rdata_axi = '0; rresp = 2'b00; rlast = 1'b1; rvalid = 1'b0;
      bid = '0; bresp = 2'b00; bvalid = 1'b0;

      // Reset state
      tick();
      tick();
      checkOutput("reset valids", {arvalid, awvalid, wvalid}, 3'b000);
      checkOutput("reset addr_ok", addr_ok, 0);
      checkOutput("reset data_ok", data_ok, 0);
      checkOutput("reset readies", {rready, bready}, 2'b00);
      aresetn = 1'b1;
      tick();
      checkOutput("post-reset readies", {rready, bready}, 2'b11);
      checkOutput("post-reset rdata", rdata, 0);

      // Table-driven transactions
      for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

      // Byte write with W accepted three cycles after AW
      wready = 1'b0;
      drivePort(0, 1'b1, 2'd0, 32'h80000003, 32'hAB000000, 1'b0);
      #1;
      checkOutput("late-w addr_ok", addr_ok, 2'b01);
      expPtr = 1;
      tick();
      req = '0;
      #1;
      checkOutput("late-w aw+w valid", {awvalid, wvalid}, 2'b11);
      checkOutput("late-w wstrb", wstrb, 4'b1000);
      tick();
      checkOutput("late-w aw dropped", {awvalid, wvalid}, 2'b01);
      tick();
      checkOutput("late-w w held", wvalid, 1);
      tick();
      wready = 1'b1;
      #1;
      checkOutput("late-w w held 3", wvalid, 1);
      checkOutput("late-w no data_ok", data_ok, 0);
      tick();
      checkOutput("late-w w drained", wvalid, 0);
      checkOutput("late-w still waiting", data_ok, 0);
      bvalid = 1'b1;
      bid = 4'd0;
      #1;
      checkOutput("late-w data_ok on b", data_ok, 2'b01);
      tick();
      bvalid = 1'b0;

      // Read held off while a write is outstanding
      drivePort(1, 1'b1, 2'd2, 32'h00000200, 32'h99887766, 1'b0);
      #1;
      checkOutput("hazard write grant", addr_ok, 2'b10);
      expPtr = 0;
      tick();
      drivePort(0, 1'b0, 2'd2, 32'h00000300, 32'h0, 1'b0);
      for (int c = 0; c < 5; c++) begin
         #1;
         checkOutput("hazard read blocked", addr_ok, 2'b00);
         tick();
      end
      bvalid = 1'b1;
      bid = 4'd1;
      #1;
      checkOutput("hazard write done", data_ok, 2'b10);
      checkOutput("hazard still blocked on b", addr_ok, 2'b00);
      tick();
      bvalid = 1'b0;
      #1;
      checkOutput("hazard read granted", addr_ok, 2'b01);
      expPtr = 1;
      tick();
      req = '0;
      #1;
      checkOutput("hazard arvalid", {arvalid, arid}, {1'b1, 4'd0});
      tick();
      rvalid = 1'b1;
      rid = 4'd0;
      rdata_axi = 32'h0BADF00D;
      #1;
      checkOutput("hazard read done", data_ok, 2'b01);
      tick();
      rvalid = 1'b0;

      // Round robin with both ports requesting reads, responses 2 cycles after grant
      busyM = '0;
      for (int i = 0; i < NP; i++) grantCyc[i] = -100;
      req = 2'b11;
      wr = 2'b00;
      size = {2'd2, 2'd2};
      addr = {32'h00002000, 32'h00001000};
      for (int c = 0; c <= 12; c++) begin
         reqM = (c >= 11) ? 2'b00 : 2'b11;
         req = reqM;
         rvalid = 1'b0;
         respPort = -1;
         for (int i = 0; i < NP; i++) begin
            if (busyM[i] && grantCyc[i] == c - 2) begin
               rvalid = 1'b1;
               rid = IDW'(i);
               rdata_axi = 32'hA0000000 + c;
               respPort = i;
            end
         end
         #1;
         if (respPort >= 0) begin
            checkOutput("rr data_ok", data_ok, 2'b01 << respPort);
            checkOutput("rr rdata", rdata, 32'hA0000000 + c);
         end else begin
            checkOutput("rr no data_ok", data_ok, 0);
         end
         expGrant = '0;
         for (int k = 0; k < NP; k++) begin
            int idx;
            idx = (expPtr + k) % NP;
            if (expGrant == '0 && reqM[idx] && !busyM[idx]) expGrant[idx] = 1'b1;
         end
         checkOutput("rr grant", addr_ok, expGrant);
         if (respPort >= 0) busyM[respPort] = 1'b0;
         for (int i = 0; i < NP; i++) begin
            if (expGrant[i]) begin
               busyM[i] = 1'b1;
               grantCyc[i] = c;
               expPtr = (i + 1) % NP;
            end
         end
         tick();
      end
      rvalid = 1'b0;
      req = '0;

      // Out-of-order completion plus a wrong-type response that must be dropped
      drivePort(0, 1'b0, 2'd2, 32'h00004000, 32'h0, 1'b0);
      #1;
      checkOutput("ooo grant p0", addr_ok, 2'b01);
      tick();
      drivePort(1, 1'b0, 2'd2, 32'h00005000, 32'h0, 1'b0);
      #1;
      checkOutput("ooo grant p1", addr_ok, 2'b10);
      expPtr = 0;
      tick();
      req = '0;
      bvalid = 1'b1;
      bid = 4'd0;
      #1;
      checkOutput("ooo b for read dropped", data_ok, 0);
      tick();
      bvalid = 1'b0;
      rvalid = 1'b1;
      rid = 4'd1;
      rdata_axi = 32'h11111111;
      #1;
      checkOutput("ooo data_ok p1 first", data_ok, 2'b10);
      checkOutput("ooo rdata p1", rdata, 32'h11111111);
      tick();
      rid = 4'd0;
      rdata_axi = 32'h22222222;
      #1;
      checkOutput("ooo data_ok p0 second", data_ok, 2'b01);
      checkOutput("ooo rdata p0", rdata, 32'h22222222);
      tick();
      rvalid = 1'b0;
      rdata_axi = 32'h33333333;
      #1;
      checkOutput("ooo rdata held", rdata, 32'h22222222);
      checkOutput("ooo idle data_ok", data_ok, 0);
      rid = 4'd3;
      rvalid = 1'b1;
      #1;
      checkOutput("unknown rid dropped", data_ok, 0);
      tick();
      rvalid = 1'b0;

      // Reset while port 0 has a read in flight
      arready = 1'b0;
      drivePort(0, 1'b0, 2'd2, 32'h00006000, 32'h0, 1'b0);
      #1;
      checkOutput("rst-mid grant", addr_ok, 2'b01);
      tick();
      req = '0;
      #1;
      checkOutput("rst-mid arvalid held", arvalid, 1);
      aresetn = 1'b0;
      req = 2'b01;
      rvalid = 1'b1;
      rid = 4'd0;
      rdata_axi = 32'h44444444;
      #1;
      checkOutput("rst-mid valids", {arvalid, awvalid, wvalid}, 3'b000);
      checkOutput("rst-mid addr_ok", addr_ok, 0);
      checkOutput("rst-mid data_ok", data_ok, 0);
      checkOutput("rst-mid readies", {rready, bready}, 2'b00);
      tick();
      aresetn = 1'b1;
      req = '0;
      arready = 1'b1;
      #1;
      checkOutput("rst-mid late r dropped", data_ok, 0);
      checkOutput("rst-mid ar cleared", arvalid, 0);
      tick();
      rvalid = 1'b0;
      expPtr = 0;
      #1;
      checkOutput("rst-mid readies back", {rready, bready}, 2'b11);

`ifdef AXI_MPORT_BRIDGE_RESP_ERR_EN
      // Error response flagged alongside data_ok
      drivePort(0, 1'b0, 2'd2, 32'h00007000, 32'h0, 1'b0);
      #1;
      checkOutput("err grant", addr_ok, 2'b01);
      tick();
      req = '0;
      tick();
      rvalid = 1'b1;
      rid = 4'd0;
      rresp = 2'b10;
      rdata_axi = 32'h55555555;
      #1;
      checkOutput("err data_ok", data_ok, 2'b01);
      checkOutput("err resp_err", resp_err, 2'b01);
      tick();
      rvalid = 1'b0;
      rresp = 2'b00;
      #1;
      checkOutput("err resp_err clear", resp_err, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
